// File: rtl/spi_dma_w_if.sv
// rtl/spi_dma_w_if.sv - SPI beat stream and Avalon-MM burst write bundle for spi_dma_w
interface spi_dma_w_if #(
  parameter int BL = 3,
  parameter int AW = 32,
  parameter int DW = 32
);
  logic            dma_rdy;
  logic            dma_val;
  logic            dma_eof;
  logic [DW-1:0]   dma_d;
  logic            bus_wrdy;
  logic            bus_wval;
  logic [BL:0]     bus_wlen;
  logic [AW-1:0]   bus_waddr;
  logic [DW-1:0]   bus_wdata;
  logic [DW/8-1:0] bus_wbe;

  modport master (
    output dma_rdy,
    input  dma_val, dma_eof, dma_d,
    input  bus_wrdy,
    output bus_wval, bus_wlen, bus_waddr, bus_wdata, bus_wbe
  );

  modport slave (
    input  dma_rdy,
    output dma_val, dma_eof, dma_d,
    output bus_wrdy,
    input  bus_wval, bus_wlen, bus_waddr, bus_wdata, bus_wbe
  );
endinterface

// File: rtl/spi_dma_w.sv
// rtl/spi_dma_w.sv - write DMA: SPI beat stream -> FWFT FIFO -> Avalon-MM burst writes
// Optional SPI_DMA_W_BE_EN: partial byte enables on the trailing beat of an untruncated transfer.
module spi_dma_w #(
  parameter int AW = 32,
  parameter int AL = 2,
  parameter int BL = 3,
  parameter int LW = 24,
  parameter int FW = 4,
  parameter int DW = 8 * (2 ** AL)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pio_adr_we,
  input  logic        pio_len_we,
  input  logic [31:0] pio_d,
  output logic [31:0] pio_adr,
  output logic [31:0] pio_len,
  input  logic [BL:0] burstcount,
  output logic        done,
  output logic        err,
  spi_dma_w_if.master io
);
  localparam int TW  = LW - AL + 1;
  localparam int BPB = 2 ** AL;
  localparam int BW  = DW / 8;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FILL  = 2'd1;
  localparam logic [1:0] S_BURST = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]    state;
  logic [AW-1:0] adr, baddr;
  logic [LW-1:0] len, step;
  logic [TW-1:0] tot, acc, wr, rem, len_beats;
  logic [LW:0]   len_rnd;
  logic [BL:0]   n, n_nxt, bc, bcnt;
  logic [DW:0]   mem [2**FW];
  logic [DW:0]   head;
  logic [FW-1:0] wp, rp;
  logic [FW:0]   cnt;
  logic          push, pop, full, wval, last_in_burst;
  logic [BW-1:0] be;
  logic          unused_ok;

  assign unused_ok = ^pio_d[AL-1:0];

  assign len_rnd   = {1'b0, pio_d[LW-1:0]} + (LW+1)'(BPB - 1);
  assign len_beats = TW'(len_rnd >> AL);
  assign rem       = tot - wr;
  assign step      = (len < LW'(BPB)) ? len : LW'(BPB);

  // Burst size is the smallest of the programmed burst, the bus maximum and what is left.
  always_comb begin
    bc = burstcount;
    if (bc == '0) bc = (BL+1)'(1);
    if (bc > (BL+1)'(2 ** BL)) bc = (BL+1)'(2 ** BL);
    n_nxt = (rem < TW'(bc)) ? rem[BL:0] : bc;
  end

  assign full          = (cnt == (FW+1)'(2 ** FW));
  assign wval          = (state == S_BURST);
  assign io.dma_rdy    = (state != S_IDLE) && !full && (acc < tot);
  assign push          = io.dma_val && io.dma_rdy;
  assign pop           = wval && io.bus_wrdy;
  assign head          = mem[rp];
  assign last_in_burst = (bcnt == n - 1'b1);

  assign io.bus_wval  = wval;
  assign io.bus_wlen  = wval ? n : '0;
  assign io.bus_waddr = wval ? baddr : '0;
  assign io.bus_wdata = wval ? head[DW-1:0] : '0;
  assign io.bus_wbe   = wval ? be : '0;
  assign done         = (state == S_DONE);
  assign pio_adr      = 32'(adr);
  assign pio_len      = 32'(len);

`ifdef SPI_DMA_W_BE_EN
  logic trunc;
  always_comb begin
    be = '1;
    if (!trunc && (wr == tot - 1'b1) && (len[AL-1:0] != '0))
      be = BW'((1 << len[AL-1:0]) - 1);
  end
`else
  assign be = '1;
`endif

  always_ff @(posedge clk) begin
    if (push) mem[wp] <= {io.dma_eof, io.dma_d};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      adr   <= '0;
      baddr <= '0;
      len   <= '0;
      tot   <= '0;
      acc   <= '0;
      wr    <= '0;
      n     <= '0;
      bcnt  <= '0;
      wp    <= '0;
      rp    <= '0;
      cnt   <= '0;
      err   <= 1'b0;
`ifdef SPI_DMA_W_BE_EN
      trunc <= 1'b0;
`endif
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      if (push && !pop) cnt <= cnt + 1'b1;
      else if (!push && pop) cnt <= cnt - 1'b1;

      // An early eof shrinks the transfer to what has been accepted so far.
      if (push) begin
        acc <= acc + 1'b1;
        if (io.dma_eof) begin
          tot <= acc + 1'b1;
`ifdef SPI_DMA_W_BE_EN
          if (acc + 1'b1 != tot) trunc <= 1'b1;
`endif
        end
      end

      if (pio_adr_we) begin
        if (state == S_IDLE) adr <= {pio_d[AW-1:AL], {AL{1'b0}}};
        else err <= 1'b1;
      end
      if (pio_len_we && state != S_IDLE) err <= 1'b1;

      case (state)
        S_IDLE: begin
          if (pio_len_we) begin
            len   <= pio_d[LW-1:0];
            tot   <= len_beats;
            acc   <= '0;
            wr    <= '0;
            err   <= 1'b0;
`ifdef SPI_DMA_W_BE_EN
            trunc <= 1'b0;
`endif
            state <= (pio_d[LW-1:0] == '0) ? S_DONE : S_FILL;
          end
        end
        S_FILL: begin
          if (cnt >= (FW+1)'(n_nxt)) begin
            n     <= n_nxt;
            baddr <= adr;
            bcnt  <= '0;
            state <= S_BURST;
          end
        end
        S_BURST: begin
          if (pop) begin
            adr  <= adr + AW'(BPB);
            len  <= len - step;
            wr   <= wr + 1'b1;
            bcnt <= bcnt + 1'b1;
            if (last_in_burst)
              state <= ((wr + 1'b1 == tot) || head[DW]) ? S_DONE : S_FILL;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: doc/spi_dma_w.md
Name: spi_dma_w

Overview:
Write-direction DMA engine. Accepts a beat stream from the SPI side and buffers it in an internal FIFO. Drains the FIFO to memory as Avalon-MM burst writes at a PIO-programmed address and length.
Counterpart of the SPI read DMA; it shares that block's PIO register model and burstcount-driven burst sizing.

Parameters:
AW, 32, bus address width
AL, 2, log2 of bytes per beat
BL, 3, log2 of the maximum burst (2**BL beats)
LW, 24, transfer length width in bytes
FW, 4, log2 of FIFO depth in beats
DW, 8*(2**AL), data width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
pio_adr_we  in  1  load start address from pio_d
pio_len_we  in  1  load byte length from pio_d[LW-1:0] and start
pio_d  in  32  PIO write data
pio_adr  out  32  current address, zero-extended
pio_len  out  32  remaining bytes not yet written, zero-extended
burstcount  in  BL+1  maximum burst beats (1..2**BL), sampled at each burst start
done  out  1  one-cycle pulse at end of transfer
err  out  1  sticky error flag
dma_rdy  out  1  stream ready
dma_val  in  1  stream valid
dma_eof  in  1  last beat of stream
dma_d  in  DW  stream data
bus_wrdy  in  1  slave ready (inverse of waitrequest)
bus_wval  out  1  write request
bus_wlen  out  BL+1  burst length in beats
bus_waddr  out  AW  burst start address
bus_wdata  out  DW  write data
bus_wbe  out  DW/8  byte enables

Behaviour:
- Reset values: all outputs 0; state IDLE; FIFO empty; adr=0, len=0.
- pio_adr_we: loads adr; low AL bits forced to 0. Ignored when not IDLE, and err is set.
- pio_len_we in IDLE:
  - Loads len; total beats = ceil(len / 2**AL).
  - len=0: done pulses on the next cycle, no bus activity.
  - Otherwise IDLE->FILL next cycle.
- pio_len_we while busy: ignored; err is set. err clears only on reset or on a pio_len_we accepted in IDLE.
- Stream accept: beat accepted on dma_val & dma_rdy.
  - dma_rdy = (state != IDLE) & FIFO not full & accepted beats < total beats.
  - FIFO is first-word-fall-through, depth 2**FW. It stores {eof, data}.
  - If dma_eof is accepted early, total beats is truncated to the beats accepted so far, and dma_rdy drops.
- Burst size: n = min(max(burstcount,1), 2**BL, remaining beats).
- FILL->BURST when FIFO count >= n, or when every remaining beat is already in the FIFO (eof seen). Transition takes one cycle after the condition holds.
- BURST:
  - bus_wval=1; bus_waddr and bus_wlen=n are held for the whole burst.
  - Each bus_wval & bus_wrdy pops one FIFO beat onto bus_wdata.
  - bus_wval never deasserts mid-burst, because data is pre-buffered.
- Per beat: adr += 2**AL; len -= min(len, 2**AL). adr wraps modulo 2**AW.
- After the last beat of a burst: go to FILL if beats remain, else DONE.
- DONE: done=1 for one cycle, then IDLE. With an early eof, pio_len shows the unwritten byte count, which may be nonzero.
- Simultaneous accept and pop in one cycle: FIFO count unchanged.
- bus_wbe is all ones except as described under Optional Feature.

Optional Feature:
SPI_DMA_W_BE_EN
- Defined: on the final beat of a non-eof-truncated transfer, bus_wbe enables only the low (len mod 2**AL) bytes, or all bytes when the remainder is 0.
- Undefined: bus_wbe is all ones always; a trailing partial beat writes the full word.

Test Plan:
- adr=0x1000, len=64, burstcount=4, stream 16 beats, bus_wrdy=1 -> 4 bursts at 0x1000/0x1010/0x1020/0x1030, bus_wlen=4; done pulses once; pio_len=0; pio_adr=0x1040.
- len=20, burstcount=8 -> 5 beats as one burst with bus_wlen=5. Under SPI_DMA_W_BE_EN the final beat has bus_wbe=4'b1111; len=22 gives a final bus_wbe of 4'b0011.
- len=64 with dma_eof on beat 6 -> one burst of 4, then one burst of 2; done pulses; pio_len=40.
- bus_wrdy toggling 1/0 every cycle during a 4-beat burst -> bus_wval, bus_waddr and bus_wlen remain stable; all 4 data words appear in order.
- pio_len_we during BURST -> err=1; the transfer completes unchanged. Reset asserted mid-burst -> all outputs 0 next edge; FIFO empty.
- len=0 -> done pulses 1 cycle after pio_len_we; bus_wval stays 0; dma_rdy stays 0.
